// File: rtl/serial_adder_pkg.sv
// serial_adder shared types
// state encoding and counter sizing
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// serial_fa_cell: one-bit full adder
// with the running carry held in a flop
module serial_fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic s,
  output logic co,
  output logic carry
);

  assign s  = x ^ y ^ carry;
  assign co = (x & y) | (carry & (x ^ y));

  // carry flop: cleared on load, advanced per bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= co;
    end
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add
// FSM, bit counter and shift registers
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             fa_s;
  logic             fa_co;
  logic             fa_c;
  logic             clr;
  logic             en;

  assign clr = (state == IDLE) && start;
  assign en  = (state == ADD);

  serial_fa_cell u_fa (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .x     (sh_a[0]),
    .y     (sh_b[0]),
    .s     (fa_s),
    .co    (fa_co),
    .carry (fa_c)
  );

  // new bit enters at the MSB so the word
  // is right-aligned after WIDTH shifts
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = fa_s;
    end else begin : g_wn
      assign res_nxt = {fa_s, res[WIDTH-1:1]};
    end
  endgenerate

  // sequencer: load, shift per bit, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= res_nxt;
            carry_out <= fa_co;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner
// sequences and random model check
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks;
  int errors;
  logic [W-1:0] held_s;
  logic         held_c;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t tbl [6];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // one full operation with timing checks
  task automatic run_op(input logic [W-1:0] xa,
                        input logic [W-1:0] xb,
                        input logic [W-1:0] es,
                        input logic         ec,
                        input string        nm);
    int bn;
    int dn;
    bit stable;
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~xa;
    b = ~xb;
    bn = 0;
    dn = 0;
    stable = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (busy) bn++;
      if (done) dn++;
      if (sum !== held_s || carry_out !== held_c)
        stable = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, bn, W);
    chk({nm, "_stable"}, stable, 1);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, carry_out, ec);
    if (done) dn++;
    @(negedge clk);
    if (done) dn++;
    chk({nm, "_one_done"}, dn, 1);
    chk({nm, "_hold"}, {carry_out, sum}, {ec, es});
    held_s = es;
    held_c = ec;
  endtask

  initial begin
    int dcnt;
    int d1;
    int d2;
    logic [W-1:0] s1;
    logic         c1;
    logic [W-1:0] s2;
    logic         c2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   ref_v;

    checks = 0;
    errors = 0;
    held_s = '0;
    held_c = 1'b0;
    tbl[0] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    tbl[4] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, carry_out, sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].s,
             tbl[i].c, $sformatf("vec%0d", i));

    // start held high, operands changed mid-ADD
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    dcnt = 0;
    s1 = '0;
    c1 = 1'b0;
    s2 = '0;
    c2 = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a = 8'h01;
        b = 8'h02;
      end
      if (done) begin
        dcnt++;
        if (d1 < 0) begin
          d1 = k;
          s1 = sum;
          c1 = carry_out;
        end else begin
          d2 = k;
          s2 = sum;
          c2 = carry_out;
        end
      end
      if (k == 19) start = 1'b0;
    end
    chk("hold_first_at", d1, 9);
    chk("hold_first_res", {c1, s1}, 9'h100);
    chk("hold_second_at", d2, 19);
    chk("hold_second_res", {c2, s2}, 9'h003);
    chk("hold_done_cnt", dcnt, 2);
    held_s = 8'h03;
    held_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_no_restart", busy, 0);

    // async reset in the 4th ADD cycle
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, carry_out, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    held_s = '0;
    held_c = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, "post_rst");

    // random regression against plain a+b
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, ref_v[W-1:0], ref_v[W],
             $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
